// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command codes, FSM state
// encoding and the fixed register-file addresses used for ALU operands.
package sys_ctrl_pkg;

  // Command bytes recognised in the idle state
  localparam logic [7:0] CmdRegWr   = 8'hAA;
  localparam logic [7:0] CmdRegRd   = 8'hBB;
  localparam logic [7:0] CmdAluOp   = 8'hCC;
  localparam logic [7:0] CmdAluNoOp = 8'hDD;

  // FSM state encoding
  localparam int unsigned StateWidth = 4;

  localparam logic [StateWidth-1:0] StIdle    = 4'd0;
  localparam logic [StateWidth-1:0] StWrAddr  = 4'd1;
  localparam logic [StateWidth-1:0] StWrData  = 4'd2;
  localparam logic [StateWidth-1:0] StRdAddr  = 4'd3;
  localparam logic [StateWidth-1:0] StRdWait  = 4'd4;
  localparam logic [StateWidth-1:0] StOpA     = 4'd5;
  localparam logic [StateWidth-1:0] StOpB     = 4'd6;
  localparam logic [StateWidth-1:0] StAluFun  = 4'd7;
  localparam logic [StateWidth-1:0] StAluWait = 4'd8;
  localparam logic [StateWidth-1:0] StSendRd  = 4'd9;
  localparam logic [StateWidth-1:0] StSendLo  = 4'd10;
  localparam logic [StateWidth-1:0] StSendHi  = 4'd11;

  // Register-file locations the ALU reads its operands from
  localparam int unsigned OpAAddr = 0;
  localparam int unsigned OpBAddr = 1;

endpackage

// File: rtl/sys_ctrl.sv
// System controller: decodes command bytes from the receive path, drives
// register-file reads/writes and ALU requests, and pushes results into the
// transmit FIFO. All outputs come straight from flops.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic                    alu_en,
  output logic [3:0]              alu_fun,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_full
);

  logic [StateWidth-1:0]   state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;

  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  // Next-state and next-output logic; strobes default low so each fires once
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_data_d    = rd_data_q;
    alu_res_d    = alu_res_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_valid_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    tx_data_d    = tx_data_q;

    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(CmdRegWr)) begin
            state_d = StWrAddr;
          end else if (rx_data == DATA_WIDTH'(CmdRegRd)) begin
            state_d = StRdAddr;
          end else if (rx_data == DATA_WIDTH'(CmdAluOp)) begin
            state_d = StOpA;
          end else if (rx_data == DATA_WIDTH'(CmdAluNoOp)) begin
            state_d = StAluFun;
          end
          // Unknown bytes are dropped; remain idle
        end
      end

      StWrAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = StWrData;
        end
      end

      StWrData: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = rx_data;
          state_d      = StIdle;
        end
      end

      StRdAddr: begin
        if (rx_valid) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d    = StRdWait;
        end
      end

      StRdWait: begin
        if (rf_rd_valid) begin
          rd_data_d = rf_rd_data;
          state_d   = StSendRd;
        end
      end

      StOpA: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(OpAAddr);
          rf_wr_data_d = rx_data;
          state_d      = StOpB;
        end
      end

      StOpB: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(OpBAddr);
          rf_wr_data_d = rx_data;
          state_d      = StAluFun;
        end
      end

      StAluFun: begin
        if (rx_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[3:0];
          state_d   = StAluWait;
        end
      end

      StAluWait: begin
        if (alu_valid) begin
          alu_res_d = alu_out;
          state_d   = StSendLo;
        end
      end

      StSendRd: begin
        if (!tx_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rd_data_q;
          state_d    = StIdle;
        end
      end

      StSendLo: begin
        if (!tx_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = alu_res_q[DATA_WIDTH-1:0];
          state_d    = StSendHi;
        end
      end

      StSendHi: begin
        if (!tx_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d    = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, captured data and registered outputs; reset clears everything
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rd_data_q    <= '0;
      alu_res_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_data_q    <= rd_data_d;
      alu_res_q    <= alu_res_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign alu_en     = alu_en_q;
  assign alu_fun    = alu_fun_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: a transaction-level model turns the byte stream into
// expected strobes (with their exact cycle) and transmit bytes; a single
// negedge process compares every cycle, and directed literals pin the model.
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_full;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .rf_rd_data (rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .alu_en     (alu_en),
    .alu_fun    (alu_fun),
    .alu_out    (alu_out),
    .alu_valid  (alu_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_full    (tx_full)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [3:0] addr; logic [7:0] data; } ev_t;
  typedef struct { int unsigned earliest; logic [7:0] data; } tx_t;

  // Model state (expected events) and observation logs
  ev_t         wr_q[$];
  ev_t         rd_q[$];
  ev_t         alu_q[$];
  tx_t         tx_q[$];
  logic [7:0]  cmd_q[$];
  int          await_kind = 0;  // 0 none, 1 read return, 2 ALU return

  ev_t         wr_log[$];
  logic [3:0]  rd_log[$];
  logic [3:0]  alu_log[$];
  logic [7:0]  tx_log[$];
  int unsigned tx_cyc[$];

  int n_cmp = 0;
  int n_err = 0;
  logic prev_full = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ev_t mk(int unsigned c, logic [3:0] a, logic [7:0] d);
    ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    return e;
  endfunction

  // Byte-level model: collect a command and its arguments, emit expectations
  function automatic void model_rx(logic [7:0] b, int unsigned c);
    int need;
    if (await_kind != 0 || tx_q.size() != 0) return;  // busy: byte dropped
    if (cmd_q.size() == 0 && !(b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) return;
    cmd_q.push_back(b);
    case (cmd_q[0])
      8'hAA:   need = 3;
      8'hBB:   need = 2;
      8'hCC:   need = 4;
      default: need = 2;
    endcase
    if (cmd_q[0] == 8'hCC && cmd_q.size() == 2) wr_q.push_back(mk(c + 1, 4'd0, b));
    if (cmd_q[0] == 8'hCC && cmd_q.size() == 3) wr_q.push_back(mk(c + 1, 4'd1, b));
    if (cmd_q.size() == need) begin
      case (cmd_q[0])
        8'hAA: wr_q.push_back(mk(c + 1, cmd_q[1][3:0], b));
        8'hBB: begin rd_q.push_back(mk(c + 1, b[3:0], 8'h00)); await_kind = 1; end
        default: begin alu_q.push_back(mk(c + 1, b[3:0], 8'h00)); await_kind = 2; end
      endcase
      cmd_q.delete();
    end
  endfunction

  // Return-path model: a return only counts when the matching one is awaited
  function automatic void model_ret(int kind, logic [15:0] d, int unsigned c);
    tx_t t;
    if (kind != await_kind) return;
    await_kind = 0;
    t.earliest = c + 2;
    t.data = d[7:0];
    tx_q.push_back(t);
    if (kind == 2) begin
      t.earliest = c + 3;
      t.data = d[15:8];
      tx_q.push_back(t);
    end
  endfunction

  function automatic void model_reset();
    wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); cmd_q.delete();
    await_kind = 0;
  endfunction

  // Per-cycle comparison of all outputs against the model
  always @(negedge CLK) begin
    logic exp_wr, exp_rd, exp_alu, exp_tx;
    if (RST) begin
      check("rst_rf_wr_en", {31'b0, rf_wr_en}, 0);
      check("rst_rf_rd_en", {31'b0, rf_rd_en}, 0);
      check("rst_rf_addr", {28'b0, rf_addr}, 0);
      check("rst_rf_wr_data", {24'b0, rf_wr_data}, 0);
      check("rst_alu_en", {31'b0, alu_en}, 0);
      check("rst_alu_fun", {28'b0, alu_fun}, 0);
      check("rst_tx_data", {24'b0, tx_data}, 0);
      check("rst_tx_valid", {31'b0, tx_valid}, 0);
    end else begin
      exp_wr = (wr_q.size() != 0) && (wr_q[0].cyc == cyc);
      check("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, exp_wr});
      if (rf_wr_en) wr_log.push_back(mk(cyc, rf_addr, rf_wr_data));
      if (exp_wr) begin
        if (rf_wr_en) begin
          check("wr_addr", {28'b0, rf_addr}, {28'b0, wr_q[0].addr});
          check("wr_data", {24'b0, rf_wr_data}, {24'b0, wr_q[0].data});
        end
        void'(wr_q.pop_front());
      end

      exp_rd = (rd_q.size() != 0) && (rd_q[0].cyc == cyc);
      check("rf_rd_en", {31'b0, rf_rd_en}, {31'b0, exp_rd});
      if (rf_rd_en) rd_log.push_back(rf_addr);
      if (exp_rd) begin
        if (rf_rd_en) check("rd_addr", {28'b0, rf_addr}, {28'b0, rd_q[0].addr});
        void'(rd_q.pop_front());
      end

      exp_alu = (alu_q.size() != 0) && (alu_q[0].cyc == cyc);
      check("alu_en", {31'b0, alu_en}, {31'b0, exp_alu});
      if (alu_en) alu_log.push_back(alu_fun);
      if (exp_alu) begin
        if (alu_en) check("alu_fun", {28'b0, alu_fun}, {28'b0, alu_q[0].addr});
        void'(alu_q.pop_front());
      end

      // A push may happen only once its byte is ready and FIFO was not full
      exp_tx = (tx_q.size() != 0) && (tx_q[0].earliest <= cyc) && !prev_full;
      check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_tx});
      if (tx_valid) begin
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
      if (exp_tx) begin
        if (tx_valid) check("tx_data", {24'b0, tx_data}, {24'b0, tx_q[0].data});
        void'(tx_q.pop_front());
      end
    end
    prev_full = tx_full;
  end

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    model_rx(b, cyc);
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic ret_rd(input logic [7:0] d, input int dly);
    repeat (dly) @(posedge CLK);
    @(posedge CLK); #1;
    rf_rd_data  = d;
    rf_rd_valid = 1'b1;
    model_ret(1, {8'h00, d}, cyc);
    @(posedge CLK); #1;
    rf_rd_valid = 1'b0;
  endtask

  task automatic ret_alu(input logic [15:0] d, input int dly);
    repeat (dly) @(posedge CLK);
    @(posedge CLK); #1;
    alu_out   = d;
    alu_valid = 1'b1;
    model_ret(2, d, cyc);
    @(posedge CLK); #1;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    rx_data = 8'h00; rx_valid = 1'b0;
    rf_rd_data = 8'h00; rf_rd_valid = 1'b0;
    alu_out = 16'h0000; alu_valid = 1'b0;
    tx_full = 1'b0;
    idle(3);
    RST = 1'b0;
    idle(2);

    // Register write: AA 05 3C
    send(8'hAA); send(8'h05); send(8'h3C);
    idle(4);
    check("w1_count", wr_log.size(), 1);
    check("w1_addr", {28'b0, wr_log[0].addr}, 32'h5);
    check("w1_data", {24'b0, wr_log[0].data}, 32'h3C);
    check("w1_no_tx", tx_log.size(), 0);

    // Register read with a byte arriving during the wait (must be dropped)
    send(8'hBB); send(8'h05);
    send(8'hAA);
    ret_rd(8'h3C, 4);
    idle(4);
    check("r1_rd_count", rd_log.size(), 1);
    check("r1_rd_addr", {28'b0, rd_log[0]}, 32'h5);
    check("r1_tx_count", tx_log.size(), 1);
    check("r1_tx_byte", {24'b0, tx_log[0]}, 32'h3C);

    // Stray ALU result while idle, then CC 10 20 00 -> 0x0030
    ret_alu(16'hBEEF, 0);
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    ret_alu(16'h0030, 2);
    idle(5);
    check("a1_wr_count", wr_log.size(), 3);
    check("a1_opa", {20'b0, wr_log[1].addr, wr_log[1].data}, 32'h010);
    check("a1_opb", {20'b0, wr_log[2].addr, wr_log[2].data}, 32'h120);
    check("a1_fun", {28'b0, alu_log[0]}, 32'h0);
    check("a1_tx_lo", {24'b0, tx_log[1]}, 32'h30);
    check("a1_tx_hi", {24'b0, tx_log[2]}, 32'h00);

    // DD 02 with the transmit FIFO full when 0x1234 returns
    send(8'hDD); send(8'h02);
    tx_full = 1'b1;
    ret_alu(16'h1234, 1);
    idle(5);
    tx_full = 1'b0;
    idle(5);
    check("a2_fun", {28'b0, alu_log[1]}, 32'h2);
    check("a2_tx_count", tx_log.size(), 5);
    check("a2_tx_lo", {24'b0, tx_log[3]}, 32'h34);
    check("a2_tx_hi", {24'b0, tx_log[4]}, 32'h12);
    check("a2_tx_gap", tx_cyc[4] - tx_cyc[3], 1);

    // Unknown byte dropped, then AA 01 FF
    send(8'h55); send(8'hAA); send(8'h01); send(8'hFF);
    idle(4);
    check("d1_wr_count", wr_log.size(), 4);
    check("d1_wr", {20'b0, wr_log[3].addr, wr_log[3].data}, 32'h1FF);

    // Reset after AA 03 aborts the write; BB 03 afterwards is a read
    send(8'hAA); send(8'h03);
    RST = 1'b1;
    model_reset();
    idle(2);
    RST = 1'b0;
    send(8'hBB); send(8'h03);
    ret_rd(8'h77, 3);
    idle(5);
    check("x1_no_wr", wr_log.size(), 4);
    check("x1_rd_addr", {28'b0, rd_log[rd_log.size() - 1]}, 32'h3);
    check("x1_tx_byte", {24'b0, tx_log[tx_log.size() - 1]}, 32'h77);

    idle(10);
    check("end_wr_pending", wr_q.size(), 0);
    check("end_rd_pending", rd_q.size(), 0);
    check("end_alu_pending", alu_q.size(), 0);
    check("end_tx_pending", tx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end by 200000");
    $fatal(1, "timeout");
  end

endmodule
